// File: rtl/bcd_decoder_if.sv
// rtl/bcd_decoder_if.sv - digit-in / one-hot-out stream bundle for bcd_decoder (err_cnt under BCD_DEC_ERRCNT_EN)
interface bcd_decoder_if #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [3:0]    in_bcd;
    logic          in_valid;
    logic          in_ready;
    logic [9:0]    out_onehot;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
`ifdef BCD_DEC_ERRCNT_EN
    logic [ERRW-1:0] err_cnt;

    modport slave (
        input  in_bcd, in_valid, out_ready,
        output in_ready, out_onehot, out_err, out_valid, level, err_cnt
    );
    modport master (
        output in_bcd, in_valid, out_ready,
        input  in_ready, out_onehot, out_err, out_valid, level, err_cnt
    );
`else
    modport slave (
        input  in_bcd, in_valid, out_ready,
        output in_ready, out_onehot, out_err, out_valid, level
    );
    modport master (
        output in_bcd, in_valid, out_ready,
        input  in_ready, out_onehot, out_err, out_valid, level
    );
`endif
endinterface

// File: rtl/bcd_decoder.sv
// rtl/bcd_decoder.sv - BCD to one-hot decoder with output FIFO; BCD_DEC_ERRCNT_EN adds a saturating error counter
module bcd_decoder #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [10:0]   mem_q [DEPTH];
    logic [10:0]   dec_word;
    logic [10:0]   head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Pointer MSB is the wrap bit: equal low bits with differing MSBs means full.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    always_comb begin
        dec_word = 11'b0;
        if (bus.in_bcd < 4'd10) begin
            dec_word[9:0] = 10'b1 << bus.in_bcd;
        end else begin
            dec_word[10] = 1'b1;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is left unreset; the empty gating below masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= dec_word;
        end
    end

    assign head           = mem_q[rptr_q[AW-1:0]];
    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.out_onehot = empty ? 10'b0 : head[9:0];
    assign bus.out_err    = empty ? 1'b0 : head[10];
    assign bus.level      = wptr_q - rptr_q;

`ifdef BCD_DEC_ERRCNT_EN
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && dec_word[10] && (err_cnt_q != {ERRW{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_bcd_decoder.sv
// tb/tb_bcd_decoder.sv - directed self-checking bench for bcd_decoder (err_cnt checks under BCD_DEC_ERRCNT_EN)
module tb_bcd_decoder;
    localparam int DEPTH = 4;
    localparam int ERRW  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   exp_err_cnt;

    bcd_decoder_if #(.DEPTH(DEPTH), .ERRW(ERRW)) bus ();

    bcd_decoder #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [9:0] oh, input logic err, input logic vld);
        check_eq({tag, "_onehot"}, 32'(bus.out_onehot), 32'(oh));
        check_eq({tag, "_err"}, 32'(bus.out_err), 32'(err));
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'(vld));
    endtask

    task automatic check_errcnt(input string tag);
`ifdef BCD_DEC_ERRCNT_EN
        check_eq(tag, 32'(bus.err_cnt), 32'(exp_err_cnt));
`endif
    endtask

    task automatic model_err(input logic [3:0] d);
        if (d >= 4'd10 && exp_err_cnt < (1 << ERRW) - 1) begin
            exp_err_cnt++;
        end
    endtask

    initial begin
        logic [9:0] fill_exp [4];
        logic [3:0] fill_in  [5];
        checks      = 0;
        failures    = 0;
        exp_err_cnt = 0;
        fill_in[0] = 4'd3; fill_in[1] = 4'd1; fill_in[2] = 4'd4; fill_in[3] = 4'd1; fill_in[4] = 4'd5;
        fill_exp[0] = 10'b0000001000; fill_exp[1] = 10'b0000000010;
        fill_exp[2] = 10'b0000010000; fill_exp[3] = 10'b0000000010;

        rst_n        = 1'b0;
        bus.in_bcd   = 4'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_level", 32'(bus.level), 32'd0);
        check_head("rst", 10'b0, 1'b0, 1'b0);
        check_errcnt("rst_err_cnt");

        // Fill to full; the fifth digit must be refused.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = fill_in[i];
            tick();
            check_eq($sformatf("fill_level_%0d", i), 32'(bus.level), 32'((i < 4) ? i + 1 : 4));
        end
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_head("full_head", fill_exp[0], 1'b0, 1'b1);
        // Push and pop while full: only the pop takes effect.
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_eq("full_pop_level", 32'(bus.level), 32'd3);
        check_eq("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            check_head($sformatf("drain_%0d", i), fill_exp[i], 1'b0, 1'b1);
            tick();
        end
        check_head("drain_empty", 10'b0, 1'b0, 1'b0);
        check_eq("drain_level", 32'(bus.level), 32'd0);

        // Pop while empty changes nothing.
        tick();
        check_eq("empty_pop_level", 32'(bus.level), 32'd0);
        check_eq("empty_pop_valid", 32'(bus.out_valid), 32'd0);

        // Single push of 9 is visible for exactly one cycle.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 4'd9;
        tick();
        bus.in_valid = 1'b0;
        check_head("lat_9", 10'b1000000000, 1'b0, 1'b1);
        check_eq("lat_level", 32'(bus.level), 32'd1);
        tick();
        check_head("lat_gone", 10'b0, 1'b0, 1'b0);

        // Simultaneous push/pop at level 2.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_bcd    = 4'd2;
        tick();
        bus.in_bcd = 4'd3;
        tick();
        check_eq("pp_pre_level", 32'(bus.level), 32'd2);
        bus.in_bcd    = 4'd7;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_eq("pp_level", 32'(bus.level), 32'd2);
        check_head("pp_head3", 10'b0000001000, 1'b0, 1'b1);
        tick();
        check_head("pp_head7", 10'b0010000000, 1'b0, 1'b1);
        tick();
        check_head("pp_empty", 10'b0, 1'b0, 1'b0);

        // All sixteen codes at full throughput.
        for (int d = 0; d < 16; d++) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = 4'(d);
            model_err(4'(d));
            tick();
            check_head($sformatf("code_%0d", d), (d < 10) ? (10'b1 << d) : 10'b0, (d >= 10), 1'b1);
            check_eq($sformatf("code_level_%0d", d), 32'(bus.level), 32'd1);
            check_errcnt($sformatf("code_err_cnt_%0d", d));
        end
        bus.in_valid = 1'b0;
        tick();
        check_head("code_empty", 10'b0, 1'b0, 1'b0);

        // Reset mid-stream with three entries buffered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_bcd = 4'(i + 12);
            model_err(4'(i + 12));
            tick();
        end
        bus.in_valid = 1'b0;
        check_eq("mid_level", 32'(bus.level), 32'd3);
        check_errcnt("mid_err_cnt");
        #2;
        rst_n = 1'b0;
        exp_err_cnt = 0;
        #1;
        check_eq("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("mrst_level", 32'(bus.level), 32'd0);
        check_head("mrst", 10'b0, 1'b0, 1'b0);
        check_errcnt("mrst_err_cnt");
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bcd   = 4'd4;
        tick();
        bus.in_valid = 1'b0;
        check_eq("post_rst_level", 32'(bus.level), 32'd1);
        check_head("post_rst", 10'b0000010000, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        tick();

        // Error counter saturation: 15 five times reads 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = 4'd15;
            model_err(4'd15);
            tick();
            check_head($sformatf("sat_%0d", i), 10'b0, 1'b1, 1'b1);
            check_errcnt($sformatf("sat_err_cnt_%0d", i));
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("final_level", 32'(bus.level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_decoder.md
# bcd_decoder

Streaming BCD-to-one-hot decoder: the receive-side counterpart of the 10-input BCD encoder. It accepts 4-bit BCD digits over a valid/ready handshake, decodes each to a 10-bit one-hot vector with an error flag for non-BCD codes, and buffers results in a small FIFO toward a downstream consumer. It sits between a digit source (encoder output, serial deserializer, keypad scanner) and one-hot consumers such as 7-segment or LED drivers.

## Interface
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2
- ERRW, 8, width of the error counter (used only when BCD_DEC_ERRCNT_EN is defined)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_bcd  input  4  BCD digit
- in_valid  input  1  in_bcd is valid this cycle
- in_ready  output  1  block can accept a digit this cycle
- out_onehot  output  10  decoded digit at FIFO head; bit k is set for digit k
- out_err  output  1  head entry was a non-BCD code (10–15)
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts the head this cycle
- level  output  $clog2(DEPTH)+1  number of occupied entries
- err_cnt  output  ERRW  saturating count of accepted non-BCD codes (present only with BCD_DEC_ERRCNT_EN)

## Operation
- Push: when in_valid && in_ready, the decoded word {err, onehot} is written at the write pointer and the write pointer increments.
- Decode rules:
  - in_bcd 0–9 → onehot = 1<<in_bcd, err = 0.
  - in_bcd 10–15 → onehot = 10'b0, err = 1.
  - Error entries are stored and delivered like any other entry; they are never dropped.
- Pop: when out_valid && out_ready, the read pointer increments.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit, so pointers wrap naturally modulo 2·DEPTH.
  - Empty: pointers are equal.
  - Full: low bits are equal and the MSBs differ.
- Flow-control outputs:
  - in_ready = !full
  - out_valid = !empty
  - level = wptr − rptr
- Head outputs: out_onehot and out_err show the head entry whenever out_valid=1, and are 0 when empty.
- Rules at the FIFO boundaries:
  - Push when full is impossible, because in_ready=0. in_valid asserted while full is ignored, and no state changes.
  - Pop when empty is ignored.
  - Push and pop in the same cycle, not empty and not full: both happen and level is unchanged.
  - Push and pop in the same cycle when full: only the pop happens, because in_ready=0 that cycle. in_ready rises the next cycle.
  - Push when empty: there is no bypass. The entry appears on out_valid the following cycle.
- Upstream may hold in_valid high with a changing in_bcd. Each accepted cycle is a separate digit.

## Timing
- Reset (rst_n=0, asynchronous):
  - Pointers clear and err_cnt=0.
  - in_ready=1, out_valid=0, out_onehot=0, out_err=0, level=0.
  - FIFO storage need not be cleared.
- Reset mid-stream discards all buffered entries immediately. The first post-reset push is captured on the first rising edge with rst_n=1.
- Latency: a digit accepted at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1) when the FIFO was empty.
- Throughput: one digit per cycle sustained when out_ready is held at 1.
- All outputs are registered or derived only from pointer and storage registers. There is no combinational path from in_* to out_* or from out_ready to in_ready.

## Configuration
- BCD_DEC_ERRCNT_EN:
  - Defined: err_cnt exists. It increments by 1 on every accepted push with in_bcd ≥ 10 and saturates at 2^ERRW−1 (no wrap). It is cleared only by reset.
  - Not defined: the err_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-stream with level=3 → outputs immediately show in_ready=1, out_valid=0, level=0, out_onehot=0; err_cnt=0 if enabled.
- All codes: push in_bcd 0..15 with out_ready=1 → out_onehot equals 1<<d and out_err=0 for 0–9; out_onehot=0 and out_err=1 for 10–15; err_cnt=6 with the macro defined.
- Fill/full: out_ready=0, push 3,1,4,1,5 with DEPTH=4 → in_ready=0 after the 4th push, the 5th digit is not accepted, level=4. Then out_ready=1 → outputs 10'b0000001000, 10'b0000000010, 10'b0000010000, 10'b0000000010 in order, and in_ready=1 after the first pop.
- Simultaneous push/pop at level=2: push 7 while popping → level stays 2 and 10'b0010000000 later exits in FIFO order.
- Empty pop and latency: out_ready=1 with the FIFO empty → no change. A single push of 9 at edge N → out_valid=1 and out_onehot=10'b1000000000 in cycle N+1 only.
- Saturation (ERRW=2, macro defined): push 15 five times → err_cnt reads 1,2,3,3,3.
